vga_timing_gen: RTL and testbench

Generates the 640x480@60 Hz VGA raster: horizontal/vertical pixel counters, sync pulses, visible-area flag and line/frame strobes. Sits at the head of the video pipeline. Its `pixel_x`, `pixel_y` and `video_on` drive every renderer (net, paddles, ball, score), and its `hsync`/`vsync` go to the VGA connector through the same output register stage as RGB. Renderers sample these signals on every `clk` edge, so the block is normally built with `CLK_DIV = 1` and `clk` = 25.175 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster generator: pixel/line counters, sync pulses, visible flag and strobes.
// Every output is registered and decoded from the next-state counters, so all outputs line up.
module vga_timing_gen #(
    parameter int unsigned H_VIDEO     = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VIDEO     = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned CLK_DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 4) begin : gen_bad_div
            $error("vga_timing_gen: CLK_DIV must be in 1..4");
        end
    endgenerate

    // Inclusive bounds keep every constant inside 10 bits even at the 1024 limit.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VID_LAST = 10'(H_VIDEO - 1);
    localparam logic [9:0] V_VID_LAST = 10'(V_VIDEO - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIDEO + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VIDEO + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIDEO + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VIDEO + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

    logic [1:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       pix_tick_q, pix_tick_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? 2'd0 : div_q + 2'd1;
        x_d   = x_q;
        y_d   = y_q;

        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        video_on_d    = (x_d <= H_VID_LAST) && (y_d <= V_VID_LAST);
        hsync_d       = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        pix_tick_d    = tick;
        line_start_d  = tick && (x_d == 10'd0);
        frame_start_d = line_start_d && (y_d == 10'd0);
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    // Divider parks at its last value in reset so the first edge after release is a tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q         <= DIV_LAST;
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pix_tick    = pix_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken rasters (CLK_DIV 1 and 2) against an
// arithmetic model of position as a function of clk edges since reset release.
module tb_vga_timing_gen;

    typedef struct {
        int x, y, fc;
        bit von, hs, vs, tk, ls, fs;
    } exp_t;

    logic clk;
    logic rst;
    int   k;
    int   total;
    int   bad;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic [7:0] a_fc, b_fc, c_fc;
    logic a_von, a_hs, a_vs, a_tk, a_ls, a_fs;
    logic b_von, b_hs, b_vs, b_tk, b_ls, b_fs;
    logic c_von, c_hs, c_vs, c_tk, c_ls, c_fs;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von),
        .hsync(a_hs), .vsync(a_vs), .pix_tick(a_tk), .line_start(a_ls),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b0), .CLK_DIV(1)
    ) dut_sm (
        .clk(clk), .rst(rst), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von),
        .hsync(b_hs), .vsync(b_vs), .pix_tick(b_tk), .line_start(b_ls),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b0), .CLK_DIV(2)
    ) dut_dv (
        .clk(clk), .rst(rst), .pixel_x(c_x), .pixel_y(c_y), .video_on(c_von),
        .hsync(c_hs), .vsync(c_vs), .pix_tick(c_tk), .line_start(c_ls),
        .frame_start(c_fs), .frame_count(c_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    // Edge k after release shows tick index (k-1)/d; tick index p is pixel p of the raster.
    function automatic exp_t model(input int kk, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int d);
        exp_t e;
        int ht, vt, p;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (kk == 0) begin
            e.x = ht - 1; e.y = vt - 1; e.fc = 0;
            e.von = 0; e.hs = 1; e.vs = 1; e.tk = 0; e.ls = 0; e.fs = 0;
        end else begin
            p     = (kk - 1) / d;
            e.tk  = ((kk - 1) % d) == 0;
            e.x   = p % ht;
            e.y   = (p / ht) % vt;
            e.fc  = (p / (ht * vt) + 1) % 256;
            e.von = (e.x < hv) && (e.y < vv);
            e.hs  = !(e.x >= hv + hf && e.x < hv + hf + hsw);
            e.vs  = !(e.y >= vv + vf && e.y < vv + vf + vsw);
            e.ls  = e.tk && (e.x == 0);
            e.fs  = e.ls && (e.y == 0);
        end
        return e;
    endfunction

    task automatic check_inst(input string n, input exp_t e, input int x, input int y,
                              input int fc, input bit von, input bit hs, input bit vs,
                              input bit tk, input bit ls, input bit fs);
        check_eq({n, "_pixel_x"}, x, e.x);
        check_eq({n, "_pixel_y"}, y, e.y);
        check_eq({n, "_frame_count"}, fc, e.fc);
        check_eq({n, "_video_on"}, int'(von), int'(e.von));
        check_eq({n, "_hsync"}, int'(hs), int'(e.hs));
        check_eq({n, "_vsync"}, int'(vs), int'(e.vs));
        check_eq({n, "_pix_tick"}, int'(tk), int'(e.tk));
        check_eq({n, "_line_start"}, int'(ls), int'(e.ls));
        check_eq({n, "_frame_start"}, int'(fs), int'(e.fs));
    endtask

    task automatic check_all();
        check_inst("std", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1),
                   int'(a_x), int'(a_y), int'(a_fc), a_von, a_hs, a_vs, a_tk, a_ls, a_fs);
        check_inst("sm", model(k, 8, 2, 3, 2, 6, 1, 2, 1, 1),
                   int'(b_x), int'(b_y), int'(b_fc), b_von, b_hs, b_vs, b_tk, b_ls, b_fs);
        check_inst("dv", model(k, 8, 2, 3, 2, 6, 1, 2, 1, 2),
                   int'(c_x), int'(c_y), int'(c_fc), c_von, c_hs, c_vs, c_tk, c_ls, c_fs);
    endtask

    // rst is set away from the edge; outputs are sampled on the following falling edge.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        k = r ? k + 1 : 0;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int hs_low, von_hi, first_hs_x, ls_cnt, ls_prev, ls_period, fs_cnt;
        total = 0;
        bad   = 0;
        k     = 0;
        rst   = 1'b0;

        repeat (3) step(1'b0);

        // First line of the full-size raster plus most of the next one.
        hs_low = 0; von_hi = 0; first_hs_x = -1; ls_cnt = 0; ls_prev = 0; ls_period = 0;
        for (int i = 0; i < 1700; i++) begin
            step(1'b1);
            if (k <= 800) begin
                if (!a_hs) begin
                    hs_low++;
                    if (first_hs_x < 0) first_hs_x = int'(a_x);
                end
                if (a_von) von_hi++;
            end
            if (a_ls) begin
                ls_cnt++;
                if (ls_cnt == 2) ls_period = k - ls_prev;
                ls_prev = k;
            end
        end
        check_eq("std_hsync_low_clks", hs_low, 96);
        check_eq("std_hsync_first_x", first_hs_x, 656);
        check_eq("std_video_on_clks", von_hi, 640);
        check_eq("std_line_period", ls_period, 800);

        // Random-length runs broken by random-length mid-frame resets.
        for (int ep = 0; ep < 25; ep++) begin
            repeat ($urandom_range(400, 20)) step(1'b1);
            repeat ($urandom_range(3, 1)) step(1'b0);
        end

        // 256 shrunken frames: frame_count must wrap to 0 on the 256th frame_start.
        step(1'b0);
        fs_cnt = 0;
        for (int i = 0; i < 38300; i++) begin
            step(1'b1);
            if (b_fs) begin
                fs_cnt++;
                if (fs_cnt == 255) check_eq("sm_fc_255", int'(b_fc), 255);
                if (fs_cnt == 256) check_eq("sm_fc_wrap", int'(b_fc), 0);
            end
        end
        check_eq("sm_frame_starts", fs_cnt, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
